// File: rtl/wb_servo_pwm.sv
// rtl/wb_servo_pwm.sv - Wishbone classic slave generating glitch-free servo PWM outputs
//
// Purpose: NUM_CH servo PWM channels driven by one prescaled period counter.
//          PERIOD and PULSEn writes land in shadow registers that are copied to
//          the active registers at a period wrap, or continuously while EN=0.
// Optional feature: define SERVO_IRQ_EN for the period-wrap interrupt
//          (CTRL[1] IE, STATUS[1] IRQF write-1-to-clear, irq_o).
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wb_adr_i[5:2]              register select (0x00 CTRL, 0x04 PERIOD, 0x08 STATUS, 0x10+4n PULSEn)
//   wb_dat_i, wb_sel_i         write data and byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i  transfer control
//   wb_cti_i, wb_bte_i         ignored, every access is a classic single
//   wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o  registered response
//   pwm_o[NUM_CH-1:0]          servo pulses
//   irq_o                      period-wrap interrupt (0 without SERVO_IRQ_EN)
module wb_servo_pwm #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 20,
    parameter int PERIOD_RST = 999999
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq_o
);
    localparam int         IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] PUL_END = 4'(4 + NUM_CH);

    logic              ack_q, err_q;
    logic [31:0]       dat_q;
    logic              en;
    logic [7:0]        prescale, pre;
    logic [CNT_W-1:0]  period_sh, period_act, cnt;
    logic [CNT_W-1:0]  pulse_sh  [NUM_CH];
    logic [CNT_W-1:0]  pulse_act [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;
`ifdef SERVO_IRQ_EN
    logic              ie, irqf, w1c;
`endif

    logic [3:0]        idx, off;
    logic [IDX_W-1:0]  pidx;
    logic              sel_ctrl, sel_per, sel_stat, sel_pul, mapped;
    logic              req, wr, tick, wrap, pend;
    logic [31:0]       ctrl_rd, rdata, w_ctrl, w_per, w_pul;
    logic              unused_ok;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    assign idx      = wb_adr_i[5:2];
    assign off      = idx - 4'd4;
    assign pidx     = off[IDX_W-1:0];
    assign sel_ctrl = (idx == 4'd0);
    assign sel_per  = (idx == 4'd1);
    assign sel_stat = (idx == 4'd2);
    assign sel_pul  = (idx >= 4'd4) && (idx < PUL_END);
    assign mapped   = sel_ctrl | sel_per | sel_stat | sel_pul;

    // A new request is only accepted while no response is showing, which
    // inserts one idle cycle between acks when stb is held.
    assign req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wr   = req & wb_we_i & mapped;
    assign tick = en & (pre == prescale);
    assign wrap = tick & (cnt == period_act);

    always_comb begin
        ctrl_rd        = '0;
        ctrl_rd[0]     = en;
        ctrl_rd[15:8]  = prescale;
`ifdef SERVO_IRQ_EN
        ctrl_rd[1]     = ie;
`endif
    end

    assign w_ctrl = lane_merge(ctrl_rd, wb_dat_i, wb_sel_i);
    assign w_per  = lane_merge(32'(period_sh), wb_dat_i, wb_sel_i);
    assign w_pul  = lane_merge(32'(pulse_sh[pidx]), wb_dat_i, wb_sel_i);

    always_comb begin
        pend = (period_sh != period_act);
        for (int i = 0; i < NUM_CH; i++)
            pend = pend | (pulse_sh[i] != pulse_act[i]);
    end

    always_comb begin
        rdata = '0;
        if (sel_ctrl) rdata = ctrl_rd;
        if (sel_per)  rdata[CNT_W-1:0] = period_sh;
        if (sel_stat) begin
            rdata[0] = pend;
`ifdef SERVO_IRQ_EN
            rdata[1] = irqf;
`endif
        end
        if (sel_pul)  rdata[CNT_W-1:0] = pulse_sh[pidx];
    end

`ifdef SERVO_IRQ_EN
    assign w1c = wr & sel_stat & wb_sel_i[0] & wb_dat_i[1];
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            en         <= 1'b0;
            prescale   <= '0;
            pre        <= '0;
            cnt        <= '0;
            period_sh  <= CNT_W'(PERIOD_RST);
            period_act <= CNT_W'(PERIOD_RST);
            pwm_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pulse_sh[i]  <= '0;
                pulse_act[i] <= '0;
            end
`ifdef SERVO_IRQ_EN
            ie         <= 1'b0;
            irqf       <= 1'b0;
`endif
        end else begin
            ack_q <= req & mapped;
            err_q <= req & ~mapped;
            dat_q <= (req & ~wb_we_i & mapped) ? rdata : 32'd0;

            if (wr && sel_ctrl) begin
                en       <= w_ctrl[0];
                prescale <= w_ctrl[15:8];
`ifdef SERVO_IRQ_EN
                ie       <= w_ctrl[1];
`endif
            end
            if (wr && sel_per) period_sh <= w_per[CNT_W-1:0];
            for (int i = 0; i < NUM_CH; i++)
                if (wr && sel_pul && pidx == IDX_W'(i)) pulse_sh[i] <= w_pul[CNT_W-1:0];

            // Shadows reach the active set only at a wrap (or while stopped);
            // a write landing on the wrap edge is held over to the next wrap.
            if (wrap || !en) begin
                period_act <= period_sh;
                for (int i = 0; i < NUM_CH; i++) pulse_act[i] <= pulse_sh[i];
            end

            // pre uses ==, so a PRESCALE lowered below pre rolls through 255.
            if (!en) begin
                pre <= '0;
                cnt <= '0;
            end else begin
                pre <= tick ? 8'd0 : pre + 8'd1;
                if (tick) cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end

            for (int i = 0; i < NUM_CH; i++)
                pwm_q[i] <= en & (cnt < pulse_act[i]);

`ifdef SERVO_IRQ_EN
            if (wrap)     irqf <= 1'b1;
            else if (w1c) irqf <= 1'b0;
`endif
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign pwm_o    = pwm_q;
`ifdef SERVO_IRQ_EN
    assign irq_o    = irqf & ie;
`else
    assign irq_o    = 1'b0;
`endif

    assign unused_ok = &{1'b0, wb_cti_i, wb_bte_i, wb_adr_i[31:6], wb_adr_i[1:0],
                         w_ctrl, w_per, w_pul, off};
endmodule

// File: tb/tb_wb_servo_pwm.sv
// tb/tb_wb_servo_pwm.sv - self-checking bench for wb_servo_pwm
module tb_wb_servo_pwm;
    localparam int NUM_CH = 4;
    localparam logic [5:0]  A_CTRL = 6'h00, A_PER = 6'h04, A_STAT = 6'h08, A_PUL0 = 6'h10;
    localparam logic [3:0]  F = 4'hF;
    localparam logic [31:0] CNT_MASK = 32'h000FFFFF;
`ifdef SERVO_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000FF03;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000FF01;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [31:0]       adr, dat_w, dat_r;
    logic [3:0]        sel;
    logic              we, cyc, stb, ack, err, rty, irq;
    logic [2:0]        cti;
    logic [1:0]        bte;
    logic [NUM_CH-1:0] pwm;

    int errors = 0;
    int checks = 0;
    int pw [NUM_CH];

    wb_servo_pwm dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_r), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty), .pwm_o(pwm), .irq_o(irq)
    );

    // High-pulse lengths seen on pwm_o[0], and a free-running cycle count.
    int run_len = 0;
    int runs[$];
    int cyc_n = 0;
    always @(negedge clk) begin
        if (pwm[0]) run_len++;
        else begin
            if (run_len > 0) runs.push_back(run_len);
            run_len = 0;
        end
    end
    always @(posedge clk) cyc_n++;

    task automatic bus(input logic [5:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic ga, output logic ge, output int lat);
        @(posedge clk);
        @(negedge clk);
        adr = {26'd0, a}; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        ga = 1'b0; ge = 1'b0; rd = '0; lat = 0;
        while (!ga && !ge && lat < 8) begin
            @(posedge clk); #1;
            lat++; ga = ack; ge = err; rd = dat_r;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!ga && !ge) begin
            errors++; checks++;
            $display("FAIL bus_timeout adr=%h: no ack/err after %0d cycles, required within 1", a, lat);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r; logic ga, ge; int l;
        bus(a, 1'b1, d, s, r, ga, ge, l);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        logic ga, ge; int l;
        bus(a, 1'b0, 32'd0, F, d, ga, ge, l);
    endtask

    task automatic wait_rise(output logic ok);
        logic prev;
        prev = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!prev && pwm[0]) begin ok = 1'b1; break; end
            prev = pwm[0];
        end
    endtask

    task automatic wait_runs(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (runs.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic seen;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (pwm !== '0 || ack !== 1'b0 || err !== 1'b0 || rty !== 1'b0 || irq !== 1'b0)
            begin errors++; $display("FAIL reset_outputs pwm=%b ack=%b err=%b rty=%b irq=%b, required all 0", pwm, ack, err, rty, irq); end
        @(negedge clk) rst_n = 1'b1;
        rd(A_PER, r);  checks++; if (r !== 32'd999999) begin errors++; $display("FAIL reset_period got %0d required 999999", r); end
        rd(A_CTRL, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h required 0", r); end
        rd(A_PUL0, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_pulse0 got %h required 0", r); end
        rd(A_STAT, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_status got %h required 0", r); end
        // Constant-high channel, then reset in the middle of an ack.
        wr(A_PER, 32'd9, F); wr(A_PUL0, 32'd10, F); wr(A_CTRL, 32'd1, F);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); #1; seen = pwm[0]; end
        @(negedge clk);
        adr = {26'd0, A_CTRL}; we = 1'b0; sel = F; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b1 || pwm[0] !== 1'b1)
            begin errors++; $display("FAIL pre_reset ack=%b pwm0=%b, required 1 and 1", ack, pwm[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pwm !== '0 || ack !== 1'b0)
            begin errors++; $display("FAIL async_reset pwm=%b ack=%b, required 0 and 0", pwm, ack); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rd(A_PER, r);  checks++; if (r !== 32'd999999) begin errors++; $display("FAIL rereset_period got %0d required 999999", r); end
        rd(A_CTRL, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rereset_ctrl got %h required 0", r); end
        rd(A_PUL0, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rereset_pulse0 got %h required 0", r); end
    endtask

    task automatic test_bus;
        logic [31:0] r, m[6], d, exp_v, bmask;
        logic ga, ge;
        int l, k;
        logic [5:0] a;
        wr(A_PER, 32'd0, F);
        wr(A_PER, 32'h12345, 4'b0011);
        bus(A_PER, 1'b0, 32'd0, F, r, ga, ge, l);
        checks++; if (r !== 32'h02345) begin errors++; $display("FAIL lane_write got %h required 00002345", r); end
        checks++; if (ga !== 1'b1 || l !== 1) begin errors++; $display("FAIL ack_latency ack=%b lat=%0d, required 1 and 1", ga, l); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_width ack=%b required 0", ack); end
        bus(6'h0C, 1'b0, 32'd0, F, r, ga, ge, l);
        checks++; if (ge !== 1'b1 || ga !== 1'b0 || r !== 32'd0)
            begin errors++; $display("FAIL unmapped_read err=%b ack=%b dat=%h, required 1 0 0", ge, ga, r); end
        wr(A_PUL0, 32'h777, F);
        bus(6'h20, 1'b1, 32'hABC, F, r, ga, ge, l);
        checks++; if (ge !== 1'b1 || ga !== 1'b0)
            begin errors++; $display("FAIL pulse4_err err=%b ack=%b, required 1 0", ge, ga); end
        rd(A_PUL0, r);
        checks++; if (r !== 32'h777) begin errors++; $display("FAIL no_side_effect pulse0=%h required 777", r); end
        m[0] = 32'd0; m[1] = 32'h2345; m[2] = 32'h777; m[3] = 32'd0; m[4] = 32'd0; m[5] = 32'd0;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(0, 5);
            a = (k == 0) ? A_CTRL : (k == 1) ? A_PER : 6'(16 + 4 * (k - 2));
            d = $urandom;
            sel = 4'($urandom_range(0, 15));
            bmask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            m[k] = ((m[k] & ~bmask) | (d & bmask)) & ((k == 0) ? CTRL_MASK : CNT_MASK);
            exp_v = m[k];
            wr(a, d, sel);
            rd(a, r);
            checks++; if (r !== exp_v) begin errors++; $display("FAIL rand_rw adr=%h got %h required %h", a, r, exp_v); end
        end
        wr(A_CTRL, 32'd0, F);
    endtask

    task automatic test_back_to_back;
        logic [5:0] pat;
        @(posedge clk);
        @(negedge clk);
        adr = {26'd0, A_PER}; we = 1'b0; sel = F; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; pat[i] = ack; end
        cyc = 1'b0; stb = 1'b0;
        checks++; if (pat !== 6'b010101) begin errors++; $display("FAIL held_stb ack pattern %b required 010101", pat); end
    endtask

    task automatic check_pwm(input int per, input int ps);
        int hi[NUM_CH];
        int win, expv;
        wr(A_CTRL, 32'd0, F);
        wr(A_PER, 32'(per), F);
        for (int ch = 0; ch < NUM_CH; ch++) wr(6'(16 + 4 * ch), 32'(pw[ch]), F);
        wr(A_CTRL, 32'((ps << 8) | 1), F);
        win = (per + 1) * (ps + 1);
        repeat (2 * win + 4) @(posedge clk);
        for (int ch = 0; ch < NUM_CH; ch++) hi[ch] = 0;
        for (int t = 0; t < win; t++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NUM_CH; ch++) if (pwm[ch]) hi[ch]++;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            expv = ((pw[ch] < per + 1) ? pw[ch] : per + 1) * (ps + 1);
            checks++; if (hi[ch] !== expv)
                begin errors++; $display("FAIL pwm_duty ch%0d per=%0d ps=%0d pulse=%0d high=%0d required %0d", ch, per, ps, pw[ch], hi[ch], expv); end
        end
    endtask

    task automatic test_pwm;
        int per;
        pw[0] = 3; pw[1] = 0; pw[2] = 10; pw[3] = 5;
        check_pwm(9, 0);
        for (int it = 0; it < 4; it++) begin
            per = $urandom_range(3, 12);
            for (int ch = 0; ch < NUM_CH; ch++) pw[ch] = $urandom_range(0, per + 2);
            check_pwm(per, $urandom_range(0, 2));
        end
    endtask

    task automatic test_shadow;
        logic ok;
        logic [31:0] r;
        wr(A_CTRL, 32'd0, F); wr(A_PER, 32'd9, F); wr(A_PUL0, 32'd3, F); wr(A_CTRL, 32'd1, F);
        wait_rise(ok);
        checks++; if (!ok) begin errors++; $display("FAIL shadow_start no rising edge on pwm0, required one within 200 cycles"); end
        runs.delete();
        wr(A_PUL0, 32'd7, F);
        rd(A_STAT, r);
        checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL shadow_pend got %b required 1", r[0]); end
        wait_runs(2, ok);
        checks++; if (!ok || runs[0] !== 3 || runs[1] !== 7)
            begin errors++; $display("FAIL shadow_pulses ok=%b lengths %0d,%0d required 3,7", ok, ok ? runs[0] : -1, ok ? runs[1] : -1); end
        rd(A_STAT, r);
        checks++; if (r[0] !== 1'b0) begin errors++; $display("FAIL shadow_pend_clear got %b required 0", r[0]); end
    endtask

    task automatic test_wrap_collision;
        logic ok;
        logic [31:0] r;
        wait_rise(ok);
        checks++; if (!ok) begin errors++; $display("FAIL collide_start no rising edge on pwm0, required one within 200 cycles"); end
        // Rise is seen with cnt=1; the write's request edge then lands on cnt=9, the wrap.
        repeat (7) @(posedge clk);
        wr(A_PUL0, 32'd2, F);
        runs.delete();
        rd(A_STAT, r);
        checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL collide_pend got %b required 1", r[0]); end
        wait_runs(2, ok);
        checks++; if (!ok || runs[0] !== 7 || runs[1] !== 2)
            begin errors++; $display("FAIL collide_pulses ok=%b lengths %0d,%0d required 7,2", ok, ok ? runs[0] : -1, ok ? runs[1] : -1); end
        rd(A_STAT, r);
        checks++; if (r[0] !== 1'b0) begin errors++; $display("FAIL collide_pend_clear got %b required 0", r[0]); end
    endtask

`ifdef SERVO_IRQ_EN
    task automatic wait_irq(output logic ok, output int t);
        logic prev;
        prev = 1'b1; ok = 1'b0; t = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!prev && irq) begin ok = 1'b1; t = cyc_n; break; end
            prev = irq;
        end
    endtask

    task automatic test_irq;
        logic ok0, ok1;
        int t0, t1;
        logic [31:0] r;
        wr(A_CTRL, 32'd0, F); wr(A_PER, 32'd9, F); wr(A_STAT, 32'd2, 4'h1);
        wr(A_CTRL, 32'h0103, F);
        wait_irq(ok0, t0);
        wr(A_STAT, 32'd2, 4'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c irq=%b required 0", irq); end
        wait_irq(ok1, t1);
        checks++; if (!ok0 || !ok1 || t1 - t0 !== 20)
            begin errors++; $display("FAIL irq_period ok=%b%b spacing %0d required 20", ok0, ok1, t1 - t0); end
        repeat (18) @(posedge clk);
        wr(A_STAT, 32'd2, 4'h1);
        rd(A_STAT, r);
        checks++; if (r[1] !== 1'b1 || irq !== 1'b1)
            begin errors++; $display("FAIL irq_set_beats_clear irqf=%b irq=%b required 1 1", r[1], irq); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        cti = '0; bte = '0;
        test_reset;
        test_bus;
        test_back_to_back;
        test_pwm;
        test_shadow;
        test_wrap_collision;
`ifdef SERVO_IRQ_EN
        test_irq;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
